// File: rtl/and_term_scheduler_if.sv
// Start/done handshake bundle for and_term_scheduler.
// master drives requests, slave (the scheduler) returns status and results.
interface and_term_scheduler_if;
    logic       start;
    logic [3:0] in_vec;
    logic       ready;
    logic       busy;
    logic       done;
    logic [5:0] out_vec;
    logic       anc_err;

    modport master (
        output start, in_vec,
        input  ready, busy, done, out_vec, anc_err
    );

    modport slave (
        input  start, in_vec,
        output ready, busy, done, out_vec, anc_err
    );
endinterface

// File: rtl/and_term_scheduler.sv
// Time-multiplexed AND-term evaluator: one shared 2-input AND runs an 11-op program over a 5-bit scratch file.
// Define AND_SCHED_UNCOMPUTE_EN to add the UNCOMP pass that clears scratch and reports anc_err.
module and_term_scheduler #(
    parameter int OP_LAT = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    and_term_scheduler_if.slave bus
);
    localparam int         NUM_OPS  = 11;
    localparam logic [3:0] LAST_OP  = 4'(NUM_OPS - 1);
    localparam logic       LAT_LAST = (OP_LAT == 2);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPUTE = 2'd1;
    localparam logic [1:0] DONE    = 2'd3;
`ifdef AND_SCHED_UNCOMPUTE_EN
    localparam logic [1:0] UNCOMP   = 2'd2;
    localparam logic [3:0] UNC_LAST = 4'd4;
`endif

    // Operand index space: 0..3 = in1..in4, 4..8 = s5,s8,s10,s12,s6.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       is_res;
        logic [2:0] dst;
    } op_t;

    function automatic op_t decode(input logic [3:0] k);
        case (k)
            4'd0:    return '{a: 4'd0, b: 4'd1, is_res: 1'b0, dst: 3'd0};
            4'd1:    return '{a: 4'd0, b: 4'd2, is_res: 1'b0, dst: 3'd1};
            4'd2:    return '{a: 4'd0, b: 4'd3, is_res: 1'b0, dst: 3'd2};
            4'd3:    return '{a: 4'd1, b: 4'd2, is_res: 1'b0, dst: 3'd3};
            4'd4:    return '{a: 4'd4, b: 4'd2, is_res: 1'b0, dst: 3'd4};
            4'd5:    return '{a: 4'd8, b: 4'd3, is_res: 1'b1, dst: 3'd0};
            4'd6:    return '{a: 4'd5, b: 4'd3, is_res: 1'b1, dst: 3'd1};
            4'd7:    return '{a: 4'd6, b: 4'd1, is_res: 1'b1, dst: 3'd2};
            4'd8:    return '{a: 4'd7, b: 4'd3, is_res: 1'b1, dst: 3'd3};
            4'd9:    return '{a: 4'd1, b: 4'd3, is_res: 1'b1, dst: 3'd4};
            default: return '{a: 4'd2, b: 4'd3, is_res: 1'b1, dst: 3'd5};
        endcase
    endfunction

    logic [1:0] state;
    logic [3:0] op_cnt;
    logic       lat_cnt;
    logic [3:0] in_q;
    logic [4:0] scratch;
    logic [5:0] result;
    logic       and_q;
    logic [5:0] out_q;

    logic [3:0] op_idx;
    op_t        op;
    logic [8:0] operands;
    logic       and_now;
    logic       and_res;
    logic       retire;
    logic       uncomp_phase;
    logic [4:0] scratch_nxt;
    logic [5:0] result_nxt;

`ifdef AND_SCHED_UNCOMPUTE_EN
    logic anc_err_q;
    assign uncomp_phase = (state == UNCOMP);
    assign op_idx       = uncomp_phase ? UNC_LAST - op_cnt : op_cnt;
    assign bus.anc_err  = anc_err_q;
`else
    assign uncomp_phase = 1'b0;
    assign op_idx       = op_cnt;
    assign bus.anc_err  = 1'b0;
`endif

    assign op       = decode(op_idx);
    assign operands = {scratch, in_q};
    assign and_now  = operands[op.a] & operands[op.b];
    // With a 2-cycle unit the product is taken from the pipeline register on the second cycle.
    assign and_res  = (OP_LAT == 2) ? and_q : and_now;
    assign retire   = ((state == COMPUTE) || uncomp_phase) && (lat_cnt == LAT_LAST);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        scratch_nxt = scratch;
        result_nxt  = result;
        if (retire) begin
            if (op.is_res)
                result_nxt[op.dst] = and_res;
            else if (uncomp_phase)
                scratch_nxt[op.dst] = scratch[op.dst] ^ and_res;
            else
                scratch_nxt[op.dst] = and_res;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_cnt  <= '0;
            lat_cnt <= 1'b0;
            in_q    <= '0;
            // NOTE: the scratch file is a handful of flops, so it is cleared by reset like any register.
            scratch <= '0;
            result  <= '0;
            and_q   <= 1'b0;
            out_q   <= '0;
`ifdef AND_SCHED_UNCOMPUTE_EN
            anc_err_q <= 1'b0;
`endif
        end else begin
            and_q <= and_now;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= COMPUTE;
                        in_q    <= bus.in_vec;
                        op_cnt  <= '0;
                        lat_cnt <= 1'b0;
                    end
                end
                COMPUTE: begin
                    scratch <= scratch_nxt;
                    result  <= result_nxt;
                    lat_cnt <= retire ? 1'b0 : 1'b1;
                    if (retire) begin
                        if (op_cnt == LAST_OP) begin
                            op_cnt <= '0;
`ifdef AND_SCHED_UNCOMPUTE_EN
                            state  <= UNCOMP;
`else
                            state   <= DONE;
                            out_q   <= result_nxt;
                            scratch <= '0;
`endif
                        end else begin
                            op_cnt <= op_cnt + 4'd1;
                        end
                    end
                end
`ifdef AND_SCHED_UNCOMPUTE_EN
                UNCOMP: begin
                    scratch <= scratch_nxt;
                    lat_cnt <= retire ? 1'b0 : 1'b1;
                    if (retire) begin
                        if (op_cnt == UNC_LAST) begin
                            state     <= DONE;
                            op_cnt    <= '0;
                            out_q     <= result;
                            anc_err_q <= |scratch_nxt;
                        end else begin
                            op_cnt <= op_cnt + 4'd1;
                        end
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    op_cnt  <= '0;
                    lat_cnt <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = (state == IDLE);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.out_vec = out_q;
endmodule

// File: tb/tb_and_term_scheduler.sv
// Bench for and_term_scheduler: OP_LAT=1 and OP_LAT=2 instances share one stimulus stream and are
// compared every cycle against a countdown/boolean-equation model, plus directed literal checks.
module tb_and_term_scheduler;
`ifdef AND_SCHED_UNCOMPUTE_EN
    localparam int UNC = 5;
`else
    localparam int UNC = 0;
`endif
    localparam int LAT1 = (11 + UNC) + 1;      // negedges from accept edge to done, OP_LAT=1
    localparam int LAT2 = 2 * (11 + UNC) + 1;  // same for OP_LAT=2

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] in_vec;
    bit         chk_en = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    and_term_scheduler_if bus1 ();
    and_term_scheduler_if bus2 ();

    assign bus1.start  = start;
    assign bus1.in_vec = in_vec;
    assign bus2.start  = start;
    assign bus2.in_vec = in_vec;

    and_term_scheduler #(.OP_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    and_term_scheduler #(.OP_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The network written directly as AND terms: {n15,n14,n13,n11,n9,n7}.
    function automatic logic [5:0] terms(input logic [3:0] v);
        return {v[2] & v[3], v[1] & v[3], v[1] & v[2] & v[3],
                v[0] & v[1] & v[3], v[0] & v[2] & v[3], &v};
    endfunction

    // Model: rem = cycles left in the busy window (1 means the done cycle), 0 means idle.
    int         rem[2];
    logic [5:0] cap[2];
    logic [5:0] exp_out[2];
    int         busy_len[2];

    initial begin
        busy_len[0] = 11 + UNC;
        busy_len[1] = 2 * (11 + UNC);
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0;
            cap[d] = '0;
            exp_out[d] = '0;
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rem[d] = 0;
                exp_out[d] = '0;
            end else if (rem[d] == 0) begin
                if (start) begin
                    rem[d] = busy_len[d] + 1;
                    cap[d] = terms(in_vec);
                end
            end else begin
                rem[d] = rem[d] - 1;
                if (rem[d] == 1) exp_out[d] = cap[d];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("l1_ready",   32'(bus1.ready),   32'(rem[0] == 0));
            check("l1_busy",    32'(bus1.busy),    32'(rem[0] != 0));
            check("l1_done",    32'(bus1.done),    32'(rem[0] == 1));
            check("l1_out_vec", 32'(bus1.out_vec), 32'(exp_out[0]));
            check("l1_anc_err", 32'(bus1.anc_err), 32'd0);
            check("l1_excl",    32'(bus1.ready ^ bus1.busy), 32'd1);
            check("l2_ready",   32'(bus2.ready),   32'(rem[1] == 0));
            check("l2_busy",    32'(bus2.busy),    32'(rem[1] != 0));
            check("l2_done",    32'(bus2.done),    32'(rem[1] == 1));
            check("l2_out_vec", 32'(bus2.out_vec), 32'(exp_out[1]));
            check("l2_anc_err", 32'(bus2.anc_err), 32'd0);
            check("l2_excl",    32'(bus2.ready ^ bus2.busy), 32'd1);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(bus1.ready && bus2.ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(bus1.ready && bus2.ready), 32'd1);
    endtask

    // mode 1: pulse start mid-run and toggle in_vec every cycle after capture.
    task automatic run_one(input string tag, input logic [3:0] v, input logic [5:0] exp_v, input int mode);
        int n = 0;
        int extra = 0;
        bit seen = 1'b0;
        wait_idle();
        @(negedge clk);
        #1 start = 1'b1;
        in_vec = v;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus1.done) seen = 1'b1;
            #1 start = (mode == 1) && (n == 4);
            if (mode == 1) in_vec = ~in_vec;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'(LAT1));
        check({tag, "_out"}, 32'(bus1.out_vec), 32'(exp_v));
        check({tag, "_anc"}, 32'(bus1.anc_err), 32'd0);
        if (mode == 1) begin
            repeat (2 * LAT1) begin
                @(negedge clk);
                if (bus1.done) extra++;
            end
            check({tag, "_single_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int d1_first;
        int d2_first;
        int d2_second;
        rst_n  = 1'b0;
        start  = 1'b0;
        in_vec = 4'h0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", 32'(bus1.ready), 32'd1);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_out", 32'(bus1.out_vec), 32'd0);
        #1 rst_n = 1'b1;

        run_one("t1", 4'b1111, 6'b111111, 0);
        run_one("t2a", 4'b1110, 6'b111000, 0);
        run_one("t2b", 4'b1011, 6'b010100, 0);
        run_one("t3", 4'b1011, 6'b010100, 1);

        // Reset lands on the edge that would retire op 6 of the OP_LAT=1 instance.
        wait_idle();
        @(negedge clk);
        #1 start = 1'b1;
        in_vec = 4'b1111;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t4_ready", 32'(bus1.ready), 32'd1);
        check("t4_out", 32'(bus1.out_vec), 32'd0);
        #1 rst_n = 1'b1;
        run_one("t4b", 4'b1111, 6'b111111, 0);

        // start held high: back-to-back runs.
        wait_idle();
        @(negedge clk);
        #1 start = 1'b1;
        in_vec = 4'b0110;
        d1_first = 0;
        d2_first = 0;
        d2_second = 0;
        for (int n = 1; n <= 2 * LAT2 + 4; n++) begin
            @(negedge clk);
            if (bus1.done && d1_first == 0) d1_first = n;
            if (bus2.done) begin
                if (d2_first == 0) d2_first = n;
                else if (d2_second == 0) d2_second = n;
            end
        end
        #1 start = 1'b0;
        check("t6_l1_first", 32'(d1_first), 32'(LAT1));
        check("t6_l2_first", 32'(d2_first), 32'(LAT2));
        check("t6_l2_second", 32'(d2_second), 32'(2 * LAT2 + 1));
        check("t6_out", 32'(bus2.out_vec), 32'd0);

        // Random traffic with occasional resets; the compare process does the checking.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1 start = ($urandom_range(0, 2) == 0);
            in_vec = 4'($urandom);
            rst_n  = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        start = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
